key_reset_sequencer: RTL and testbench

Parametrised push-button front end and memory-port reset sequencer for the BSODomizer HD board top level. It synchronises and debounces NUM_KEYS active-low keys on a shared sample tick and emits per-key level and press/release pulses. On a debounced press of one selected key it drives an ordered global-reset, soft-reset and start sequence to the LPDDR2 test/loader logic, then waits for completion with an optional timeout. It also provides the board heartbeat.

---
 rtl/key_reset_sequencer_pkg.sv | 25 ++
 rtl/key_reset_sequencer_if.sv | 33 +++
 rtl/key_reset_sequencer_debounce.sv | 51 +++++
 rtl/key_reset_sequencer.sv | 169 ++++++++++++++++
 tb/tb_key_reset_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_reset_sequencer_pkg.sv
// Shared types and default parameters for the push-button front end and
// memory-port reset sequencer.
package bsod_ctrl_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_GLOBAL,
        SEQ_SOFT,
        SEQ_START,
        SEQ_WAIT_DONE
    } seq_state_t;

    localparam int DEF_NUM_KEYS           = 4;
    localparam int DEF_TICK_DIV           = 4000001;
    localparam int DEF_DEBOUNCE_DEPTH     = 3;
    localparam int DEF_SEQ_KEY            = 0;
    localparam int DEF_RST_HOLD_TICKS     = 2;
    localparam int DEF_DONE_TIMEOUT_TICKS = 0;
    localparam int DEF_HEARTBEAT_BIT      = 26;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_reset_sequencer_if.sv
// Board-side bundle of the sequencer: raw keys and done level in, debounced
// key events, memory reset controls and status out.
interface key_reset_sequencer_if
    import bsod_ctrl_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS
);
    logic [NUM_KEYS-1:0] iKEY_n;
    logic                iSEQ_DONE;
    logic [NUM_KEYS-1:0] oKEY_LEVEL;
    logic [NUM_KEYS-1:0] oPRESS;
    logic [NUM_KEYS-1:0] oRELEASE;
    logic                oTICK;
    logic                oGLOBAL_RST_n;
    logic                oSOFT_RST_n;
    logic                oSTART_n;
    logic                oBUSY;
    logic                oSEQ_REJECT;
    logic                oSEQ_TIMEOUT;
    logic                oHEARTBEAT;

    modport master (
        output iKEY_n, iSEQ_DONE,
        input  oKEY_LEVEL, oPRESS, oRELEASE, oTICK, oGLOBAL_RST_n, oSOFT_RST_n,
               oSTART_n, oBUSY, oSEQ_REJECT, oSEQ_TIMEOUT, oHEARTBEAT
    );

    modport slave (
        input  iKEY_n, iSEQ_DONE,
        output oKEY_LEVEL, oPRESS, oRELEASE, oTICK, oGLOBAL_RST_n, oSOFT_RST_n,
               oSTART_n, oBUSY, oSEQ_REJECT, oSEQ_TIMEOUT, oHEARTBEAT
    );
endinterface

// File: rtl/key_reset_sequencer_debounce.sv
// One key channel: 2-flop synchroniser, tick-sampled history and debounced
// level with one-cycle press/release pulses.
module key_debounce #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);
    logic [1:0]       sync_reg;
    logic [DEPTH-1:0] samples_reg;
    logic [DEPTH-1:0] samples_next;
    logic             level_reg;
    logic             press_reg;
    logic             release_reg;

    assign samples_next = {samples_reg[DEPTH-2:0], sync_reg[1]};

    // Samples are raw active-low values; the level is active-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= 2'b11;
            samples_reg <= '1;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], key_n};
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            if (tick) begin
                samples_reg <= samples_next;
                if (samples_next == '0 && !level_reg) begin
                    level_reg <= 1'b1;
                    press_reg <= 1'b1;
                end else if (samples_next == '1 && level_reg) begin
                    level_reg   <= 1'b0;
                    release_reg <= 1'b1;
                end
            end
        end
    end

    assign level         = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
endmodule

// File: rtl/key_reset_sequencer.sv
// Key debouncing front end plus global-reset / soft-reset / start sequencer
// for the LPDDR2 test logic, with the board heartbeat.
module key_reset_sequencer
    import bsod_ctrl_pkg::*;
#(
    parameter int NUM_KEYS           = DEF_NUM_KEYS,
    parameter int TICK_DIV           = DEF_TICK_DIV,
    parameter int DEBOUNCE_DEPTH     = DEF_DEBOUNCE_DEPTH,
    parameter int SEQ_KEY            = DEF_SEQ_KEY,
    parameter int RST_HOLD_TICKS     = DEF_RST_HOLD_TICKS,
    parameter int DONE_TIMEOUT_TICKS = DEF_DONE_TIMEOUT_TICKS,
    parameter int HEARTBEAT_BIT      = DEF_HEARTBEAT_BIT
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    key_reset_sequencer_if.slave  bus
);
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam int HOLD_MAX = max_int(RST_HOLD_TICKS, DONE_TIMEOUT_TICKS);
    localparam int HOLD_W   = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
    localparam bit TIMEOUT_EN = (DONE_TIMEOUT_TICKS > 0);
    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RST_HOLD_TICKS - 1);
    localparam logic [HOLD_W-1:0] TIMEOUT_LAST =
        HOLD_W'(TIMEOUT_EN ? DONE_TIMEOUT_TICKS - 1 : 0);

    logic [TICK_W-1:0]     tick_cnt_reg;
    logic                  tick;
    logic [NUM_KEYS-1:0]   level;
    logic [NUM_KEYS-1:0]   press;
    logic [NUM_KEYS-1:0]   release_vec;
    logic                  seq_press;
    seq_state_t            state_reg;
    logic [HOLD_W-1:0]     hold_cnt_reg;
    logic                  global_rst_n_reg;
    logic                  soft_rst_n_reg;
    logic                  start_n_reg;
    logic                  busy_reg;
    logic                  timeout_reg;
    logic [HEARTBEAT_BIT:0] heartbeat_reg;

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEPTH(DEBOUNCE_DEPTH)
            ) u_debounce (
                .clk          (iCLK),
                .rst_n        (iRST_n),
                .tick         (tick),
                .key_n        (bus.iKEY_n[gi]),
                .level        (level[gi]),
                .press_pulse  (press[gi]),
                .release_pulse(release_vec[gi])
            );
        end
    endgenerate

    assign seq_press = press[SEQ_KEY];

    // Each transition updates the reset lines on the same edge, so one phase
    // output rises exactly when the next one falls.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_reg        <= SEQ_IDLE;
            hold_cnt_reg     <= '0;
            global_rst_n_reg <= 1'b1;
            soft_rst_n_reg   <= 1'b1;
            start_n_reg      <= 1'b1;
            busy_reg         <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                SEQ_IDLE: begin
                    hold_cnt_reg <= '0;
                    if (seq_press) begin
                        state_reg        <= SEQ_GLOBAL;
                        global_rst_n_reg <= 1'b0;
                        busy_reg         <= 1'b1;
                    end
                end
                SEQ_GLOBAL: begin
                    if (tick) begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            state_reg        <= SEQ_SOFT;
                            hold_cnt_reg     <= '0;
                            global_rst_n_reg <= 1'b1;
                            soft_rst_n_reg   <= 1'b0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        end
                    end
                end
                SEQ_SOFT: begin
                    if (tick) begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            state_reg      <= SEQ_START;
                            hold_cnt_reg   <= '0;
                            soft_rst_n_reg <= 1'b1;
                            start_n_reg    <= 1'b0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        end
                    end
                end
                SEQ_START: begin
                    if (tick) begin
                        state_reg    <= SEQ_WAIT_DONE;
                        hold_cnt_reg <= '0;
                        start_n_reg  <= 1'b1;
                    end
                end
                SEQ_WAIT_DONE: begin
                    // Done is checked first so it wins over a coinciding expiry.
                    if (bus.iSEQ_DONE) begin
                        state_reg <= SEQ_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (TIMEOUT_EN && tick) begin
                        if (hold_cnt_reg == TIMEOUT_LAST) begin
                            state_reg   <= SEQ_IDLE;
                            busy_reg    <= 1'b0;
                            timeout_reg <= 1'b1;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg        <= SEQ_IDLE;
                    hold_cnt_reg     <= '0;
                    global_rst_n_reg <= 1'b1;
                    soft_rst_n_reg   <= 1'b1;
                    start_n_reg      <= 1'b1;
                    busy_reg         <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            heartbeat_reg <= '0;
        end else begin
            heartbeat_reg <= heartbeat_reg + 1'b1;
        end
    end

    assign bus.oKEY_LEVEL    = level;
    assign bus.oPRESS        = press;
    assign bus.oRELEASE      = release_vec;
    assign bus.oTICK         = tick;
    assign bus.oGLOBAL_RST_n = global_rst_n_reg;
    assign bus.oSOFT_RST_n   = soft_rst_n_reg;
    assign bus.oSTART_n      = start_n_reg;
    assign bus.oBUSY         = busy_reg;
    assign bus.oSEQ_REJECT   = seq_press & busy_reg;
    assign bus.oSEQ_TIMEOUT  = timeout_reg;
    assign bus.oHEARTBEAT    = heartbeat_reg[HEARTBEAT_BIT];
endmodule

// File: tb/tb_key_reset_sequencer.sv
// Bench: dut_a uses hold 2 / no timeout, dut_b uses hold 4 / timeout 3;
// both sample on a 4-clock tick with 3-deep debounce.
module tb_key_reset_sequencer;
    localparam int NK = 4;
    localparam int TD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    key_reset_sequencer_if #(.NUM_KEYS(NK)) bus_a ();
    key_reset_sequencer_if #(.NUM_KEYS(NK)) bus_b ();

    key_reset_sequencer #(
        .NUM_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_DEPTH(3), .SEQ_KEY(0),
        .RST_HOLD_TICKS(2), .DONE_TIMEOUT_TICKS(0), .HEARTBEAT_BIT(3)
    ) dut_a (
        .iCLK(clk), .iRST_n(rst_n), .bus(bus_a)
    );

    key_reset_sequencer #(
        .NUM_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_DEPTH(3), .SEQ_KEY(0),
        .RST_HOLD_TICKS(4), .DONE_TIMEOUT_TICKS(3), .HEARTBEAT_BIT(3)
    ) dut_b (
        .iCLK(clk), .iRST_n(rst_n), .bus(bus_b)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        int hb_first;
        int press_seen;
        bus_a.iKEY_n = '1; bus_b.iKEY_n = '1;
        bus_a.iSEQ_DONE = 1'b0; bus_b.iSEQ_DONE = 1'b0;
        rst_n = 1'b0;
        step(3);
        obs = {bus_a.oKEY_LEVEL, bus_a.oPRESS, bus_a.oRELEASE, bus_a.oGLOBAL_RST_n,
               bus_a.oSOFT_RST_n, bus_a.oSTART_n, bus_a.oBUSY, bus_a.oSEQ_REJECT,
               bus_a.oSEQ_TIMEOUT, bus_a.oHEARTBEAT, bus_a.oTICK};
        checks++;
        if (obs !== 20'h000E0) begin
            errors++; $display("FAIL reset_a: outputs=%h required=%h", obs, 20'h000E0);
        end
        obs = {bus_b.oKEY_LEVEL, bus_b.oPRESS, bus_b.oRELEASE, bus_b.oGLOBAL_RST_n,
               bus_b.oSOFT_RST_n, bus_b.oSTART_n, bus_b.oBUSY, bus_b.oSEQ_REJECT,
               bus_b.oSEQ_TIMEOUT, bus_b.oHEARTBEAT, bus_b.oTICK};
        checks++;
        if (obs !== 20'h000E0) begin
            errors++; $display("FAIL reset_b: outputs=%h required=%h", obs, 20'h000E0);
        end
        rst_n = 1'b1;
        exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(11);
        hb_first = -1; press_seen = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (bus_a.oTICK) begin
                int e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                checks++;
                if (i != e) begin
                    errors++; $display("FAIL tick_period: tick at cycle %0d required %0d", i, e);
                end
            end
            if (bus_a.oHEARTBEAT && hb_first < 0) hb_first = i;
            if (bus_a.oPRESS != '0 || bus_a.oRELEASE != '0) press_seen++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL tick_missing: %0d ticks not seen, required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (hb_first != 8) begin
            errors++; $display("FAIL heartbeat: first high at %0d required 8", hb_first);
        end
        checks++;
        if (press_seen != 0) begin
            errors++; $display("FAIL idle_pulses: %0d pulse cycles required 0", press_seen);
        end
        $display("reset: ticks/heartbeat/idle observed");
    endtask

    task automatic test_press();
        int lvl_cyc, press_cnt, press_cyc, rel_cnt;
        lvl_cyc = -1; press_cnt = 0; press_cyc = -2; rel_cnt = 0;
        bus_a.iKEY_n[1] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (bus_a.oPRESS[1]) begin press_cnt++; press_cyc = i; end
            if (bus_a.oKEY_LEVEL[1] && lvl_cyc < 0) lvl_cyc = i;
        end
        checks++;
        if (lvl_cyc < 1 || lvl_cyc > 14) begin
            errors++; $display("FAIL press_latency: level at cycle %0d required 1..14", lvl_cyc);
        end
        checks++;
        if (press_cnt != 1 || press_cyc != lvl_cyc) begin
            errors++; $display("FAIL press_pulse: count=%0d at %0d required 1 at %0d",
                               press_cnt, press_cyc, lvl_cyc);
        end
        bus_a.iKEY_n[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (bus_a.oRELEASE[1]) rel_cnt++;
        end
        checks++;
        if (rel_cnt != 1 || bus_a.oKEY_LEVEL[1] !== 1'b0) begin
            errors++; $display("FAIL release: pulses=%0d level=%b required 1 and 0",
                               rel_cnt, bus_a.oKEY_LEVEL[1]);
        end
        $display("press key1: level at %0d, %0d press, %0d release", lvl_cyc, press_cnt, rel_cnt);
    endtask

    task automatic test_bounce();
        int first, press_cnt, rel_cnt;
        bit aligned;
        aligned = 0;
        for (int i = 0; i < 8 && !aligned; i++) begin
            step(1);
            if (bus_a.oTICK) aligned = 1;
        end
        checks++;
        if (!aligned) begin
            errors++; $display("FAIL bounce_align: tick seen=%0b required 1", aligned);
            return;
        end
        // Low for one tick window, high for one, then low: samples L,H,L,L,L.
        exp_q.push_back(21);
        first = -1; press_cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            bus_a.iKEY_n[1] = (i >= 5 && i <= 8);
            step(1);
            if (bus_a.oKEY_LEVEL[1] && first < 0) first = i;
            if (bus_a.oPRESS[1]) press_cnt++;
        end
        begin
            int e;
            e = exp_q.pop_front();
            checks++;
            if (first != e) begin
                errors++; $display("FAIL bounce_level: level rose at %0d required %0d", first, e);
            end
        end
        checks++;
        if (press_cnt != 1) begin
            errors++; $display("FAIL bounce_pulse: %0d press pulses required 1", press_cnt);
        end
        bus_a.iKEY_n[1] = 1'b1;
        rel_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus_a.oRELEASE[1]) rel_cnt++;
        end
        checks++;
        if (rel_cnt != 1) begin
            errors++; $display("FAIL bounce_release: %0d pulses required 1", rel_cnt);
        end
        $display("bounce key1: level rose at cycle %0d", first);
    endtask

    task automatic test_sequence();
        bit seen, fin;
        int g_len, s_len, st_len, overlap, gap, busy_low, lows, drop;
        seen = 0;
        bus_a.iKEY_n[0] = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (bus_a.oPRESS[0]) seen = 1;
        end
        bus_a.iKEY_n[0] = 1'b1;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL seq_press: press seen=%0b required 1", seen);
            return;
        end
        step(1);
        checks++;
        if (bus_a.oGLOBAL_RST_n !== 1'b0 || bus_a.oBUSY !== 1'b1) begin
            errors++; $display("FAIL seq_entry: global_n=%b busy=%b required 0 and 1",
                               bus_a.oGLOBAL_RST_n, bus_a.oBUSY);
        end
        g_len = 0; s_len = 0; st_len = 0; overlap = 0; gap = 0; busy_low = 0; fin = 0;
        for (int i = 0; i < 40 && !fin; i++) begin
            lows = int'(!bus_a.oGLOBAL_RST_n) + int'(!bus_a.oSOFT_RST_n) + int'(!bus_a.oSTART_n);
            if (st_len > 0 && lows == 0) fin = 1;
            else begin
                if (!bus_a.oGLOBAL_RST_n) g_len++;
                if (!bus_a.oSOFT_RST_n) s_len++;
                if (!bus_a.oSTART_n) st_len++;
                if (lows > 1) overlap++;
                if (lows == 0) gap++;
                if (!bus_a.oBUSY) busy_low++;
                step(1);
            end
        end
        checks++;
        if (!fin || g_len < 5 || g_len > 8 || s_len < 5 || s_len > 8 || st_len < 1 || st_len > 4) begin
            errors++; $display("FAIL seq_phases: global=%0d soft=%0d start=%0d required 5..8/5..8/1..4",
                               g_len, s_len, st_len);
        end
        checks++;
        if (overlap != 0 || gap != 0 || busy_low != 0) begin
            errors++; $display("FAIL seq_handoff: overlap=%0d gap=%0d busy_low=%0d required 0/0/0",
                               overlap, gap, busy_low);
        end
        busy_low = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!bus_a.oBUSY) busy_low++;
        end
        checks++;
        if (busy_low != 0) begin
            errors++; $display("FAIL wait_forever: busy low %0d cycles required 0", busy_low);
        end
        exp_q.push_back(1);
        bus_a.iSEQ_DONE = 1'b1;
        drop = -1;
        for (int i = 1; i <= 5 && drop < 0; i++) begin
            step(1);
            if (!bus_a.oBUSY) drop = i;
        end
        bus_a.iSEQ_DONE = 1'b0;
        begin
            int e;
            e = exp_q.pop_front();
            checks++;
            if (drop != e || bus_a.oSEQ_TIMEOUT !== 1'b0) begin
                errors++; $display("FAIL done_latency: busy low after %0d timeout=%b required %0d and 0",
                                   drop, bus_a.oSEQ_TIMEOUT, e);
            end
        end
        $display("sequence a: global=%0d soft=%0d start=%0d done->idle %0d", g_len, s_len, st_len, drop);
    endtask

    task automatic test_reject_timeout();
        int stage, g_len, s_len, st_len, wait_len, rej_cnt, rej_ok, to_cnt, to_at_drop;
        bit was_busy, fin;
        stage = 0; g_len = 0; s_len = 0; st_len = 0; wait_len = 0;
        rej_cnt = 0; rej_ok = 0; to_cnt = 0; to_at_drop = 0; was_busy = 0; fin = 0;
        exp_q.push_back(3 * TD);
        bus_b.iKEY_n[0] = 1'b0;
        for (int i = 0; i < 150 && !fin; i++) begin
            step(1);
            if (!bus_b.oGLOBAL_RST_n) g_len++;
            if (!bus_b.oSOFT_RST_n) s_len++;
            if (!bus_b.oSTART_n) st_len++;
            if (bus_b.oBUSY && bus_b.oSTART_n && st_len > 0) wait_len++;
            if (bus_b.oSEQ_REJECT) begin
                rej_cnt++;
                if (!bus_b.oSOFT_RST_n && bus_b.oPRESS[0]) rej_ok++;
            end
            if (bus_b.oSEQ_TIMEOUT) begin
                to_cnt++;
                if (!bus_b.oBUSY) to_at_drop++;
            end
            case (stage)
                0: if (bus_b.oPRESS[0]) begin bus_b.iKEY_n[0] = 1'b1; stage = 1; end
                1: if (bus_b.oRELEASE[0]) begin bus_b.iKEY_n[0] = 1'b0; stage = 2; end
                default: ;
            endcase
            if (bus_b.oBUSY) was_busy = 1;
            else if (was_busy) fin = 1;
        end
        checks++;
        if (!fin || g_len < 13 || g_len > 16 || s_len < 13 || s_len > 16 || st_len < 1 || st_len > 4) begin
            errors++; $display("FAIL rej_phases: fin=%0b global=%0d soft=%0d start=%0d required 13..16/13..16/1..4",
                               fin, g_len, s_len, st_len);
        end
        checks++;
        if (rej_cnt != 1 || rej_ok != 1) begin
            errors++; $display("FAIL reject: pulses=%0d in_soft=%0d required 1 and 1", rej_cnt, rej_ok);
        end
        begin
            int e;
            e = exp_q.pop_front();
            checks++;
            if (wait_len != e) begin
                errors++; $display("FAIL timeout_len: wait cycles=%0d required %0d", wait_len, e);
            end
        end
        checks++;
        if (to_cnt != 1 || to_at_drop != 1) begin
            errors++; $display("FAIL timeout_pulse: pulses=%0d at_idle=%0d required 1 and 1",
                               to_cnt, to_at_drop);
        end
        $display("sequence b: rejects=%0d wait=%0d timeouts=%0d", rej_cnt, wait_len, to_cnt);
    endtask

    task automatic test_timeout_race();
        bit seen, start_seen, fin;
        int w, late_to;
        logic tick_at, busy_after, to_after;
        seen = 0;
        bus_b.iKEY_n[0] = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (bus_b.oRELEASE[0]) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL race_release: release seen=%0b required 1", seen);
        end
        bus_b.iKEY_n[0] = 1'b0;
        w = 0; start_seen = 0; fin = 0; tick_at = 1'b0; busy_after = 1'b1; to_after = 1'b1;
        for (int i = 0; i < 120 && !fin; i++) begin
            step(1);
            if (!bus_b.oSTART_n) start_seen = 1;
            else if (start_seen && bus_b.oBUSY) begin
                w++;
                if (w == 3 * TD) begin
                    tick_at = bus_b.oTICK;
                    bus_b.iSEQ_DONE = 1'b1;
                    step(1);
                    busy_after = bus_b.oBUSY;
                    to_after   = bus_b.oSEQ_TIMEOUT;
                    fin = 1;
                end
            end
        end
        bus_b.iSEQ_DONE = 1'b0;
        bus_b.iKEY_n[0] = 1'b1;
        checks++;
        if (!fin || tick_at !== 1'b1) begin
            errors++; $display("FAIL race_align: reached=%0b tick=%b required 1 and 1", fin, tick_at);
        end
        checks++;
        if (busy_after !== 1'b0 || to_after !== 1'b0) begin
            errors++; $display("FAIL race_done_wins: busy=%b timeout=%b required 0 and 0",
                               busy_after, to_after);
        end
        late_to = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bus_b.oSEQ_TIMEOUT) late_to++;
        end
        checks++;
        if (late_to != 0) begin
            errors++; $display("FAIL race_late_timeout: %0d pulses required 0", late_to);
        end
        $display("race: done at expiry, busy=%b timeout=%b", busy_after, to_after);
    endtask

    task automatic test_reset_midseq();
        bit seen;
        int first;
        seen = 0;
        bus_a.iKEY_n[0] = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (bus_a.oPRESS[0]) seen = 1;
        end
        step(1);
        checks++;
        if (!seen || bus_a.oGLOBAL_RST_n !== 1'b0) begin
            errors++; $display("FAIL midseq_enter: press=%0b global_n=%b required 1 and 0",
                               seen, bus_a.oGLOBAL_RST_n);
        end
        step(2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_a.oGLOBAL_RST_n !== 1'b1 || bus_a.oBUSY !== 1'b0 || bus_a.oKEY_LEVEL[0] !== 1'b0) begin
            errors++; $display("FAIL async_reset: global_n=%b busy=%b level=%b required 1/0/0",
                               bus_a.oGLOBAL_RST_n, bus_a.oBUSY, bus_a.oKEY_LEVEL[0]);
        end
        step(2);
        rst_n = 1'b1;
        exp_q.push_back(12);
        first = -1;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            step(1);
            if (bus_a.oPRESS[0]) first = i;
        end
        begin
            int e;
            e = exp_q.pop_front();
            checks++;
            if (first != e) begin
                errors++; $display("FAIL fresh_debounce: press at cycle %0d required %0d", first, e);
            end
        end
        bus_a.iKEY_n[0] = 1'b1;
        $display("reset mid-sequence: fresh press at cycle %0d", first);
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_sequence();
        test_reject_timeout();
        test_timeout_race();
        test_reset_midseq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
